// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary to BCD converter with saturation and leading-zero blanking
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(10**DIGITS - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   val_q, val_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic               accept;
    logic               last_bit;
    logic [BCD_W-1:0]   adjusted;
    logic [DIGITS-1:0]  blank_next;
    logic               higher_zero;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = CONVERT;
            CONVERT: if (last_bit) state_d = COMMIT;
            COMMIT:                state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == CONVERT) || (state_q == COMMIT);
    end

    // Add 3 to every nibble >= 5 before the shift; saturation keeps the top nibble from carrying out
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit i blanks only when it and every digit above it are zero; units never blank
    always_comb begin
        blank_next  = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero && (scratch_q[4*i +: 4] == 4'd0);
            blank_next[i] = higher_zero;
        end
    end

    always_comb begin
        val_d      = val_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    val_d     = (in_value > MAX_V) ? MAX_V : in_value;
                    ovf_d     = (in_value > MAX_V);
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                end
            end
            CONVERT: begin
                scratch_d = {adjusted[BCD_W-2:0], val_q[BIN_W-1]};
                val_d     = {val_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
            end
            COMMIT: begin
                bcd_d      = scratch_q;
                blank_d    = blank_next;
                overflow_d = ovf_q;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            val_q      <= val_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bcd      = bcd_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule
